// File: rtl/mul_seq_if.sv
// mul_seq_if -- operand/result bundle for the sequential multiplier.
//
// Signals (LEN = operand width):
//   start  : load a/b and begin a multiply (master -> slave)
//   a, b   : multiplicand / multiplier, LEN bits (master -> slave)
//   done   : idle with a valid product on p_hi/p_lo (slave -> master)
//   p_hi   : upper LEN bits of the product (slave -> master)
//   p_lo   : lower LEN bits of the product (slave -> master)
// Modports: master (requester side), slave (multiplier side).
interface mul_seq_if #(
    parameter int LEN = 16
);
    logic           start;
    logic [LEN-1:0] a;
    logic [LEN-1:0] b;
    logic           done;
    logic [LEN-1:0] p_hi;
    logic [LEN-1:0] p_lo;

    modport master (
        output start, a, b,
        input  done, p_hi, p_lo
    );

    modport slave (
        input  start, a, b,
        output done, p_hi, p_lo
    );
endinterface

// File: rtl/mul_seq.sv
// mul_seq -- iterative shift-add multiplier, one multiplier bit per cycle.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset (clears all state, done=1)
//   bus  : mul_seq_if.slave -- start/a/b in, done/p_hi/p_lo out
//
// A start edge loads m=a, mq=b, acc=0 and counter=LEN. Each following edge
// with start low and counter non-zero adds m to acc when mq[0] is set and
// shifts {acc, mq} right by one. After LEN iterations {acc, mq} = a*b.
// start always wins over an iteration, so it aborts and restarts a multiply.
//
// Build option: define MUL_SIGNED_EN for two's-complement operands. The sum
// is then sign-extended, the last iteration subtracts m (the multiplier's
// sign bit has negative weight) and the shift brings in the sign of the sum.
// Without it, operands are unsigned and the shift is zero-filled through the
// carry bit of the sum.
module mul_seq #(
    parameter int LEN = 16
) (
    input  logic      clk,
    input  logic      rst,
    mul_seq_if.slave  bus
);
    localparam int CW = $clog2(LEN) + 1;

    logic [CW-1:0]  cnt_r;
    logic [LEN-1:0] m_r;
    logic [LEN-1:0] acc_r;
    logic [LEN-1:0] mq_r;

    logic [CW-1:0]  cnt_s;
    logic [LEN-1:0] m_s;
    logic [LEN-1:0] acc_s;
    logic [LEN-1:0] mq_s;
    logic [LEN:0]   addend_s;
    logic [LEN:0]   sum_s;

    // Next-state computation: load on start, otherwise iterate while busy, else hold.
    always_comb begin
        cnt_s    = cnt_r;
        m_s      = m_r;
        acc_s    = acc_r;
        mq_s     = mq_r;
        addend_s = '0;
        sum_s    = '0;
        if (bus.start) begin
            cnt_s = CW'(LEN);
            m_s   = bus.a;
            mq_s  = bus.b;
            acc_s = '0;
        end else if (cnt_r != '0) begin
`ifdef MUL_SIGNED_EN
            addend_s = mq_r[0] ? {m_r[LEN-1], m_r} : '0;
            // Last iteration handles the multiplier sign bit: weight -2^(LEN-1).
            if (cnt_r == CW'(1)) begin
                sum_s = {acc_r[LEN-1], acc_r} - addend_s;
            end else begin
                sum_s = {acc_r[LEN-1], acc_r} + addend_s;
            end
`else
            addend_s = mq_r[0] ? {1'b0, m_r} : '0;
            sum_s    = {1'b0, acc_r} + addend_s;
`endif
            // {acc, mq} <= {sum, mq} >> 1; sum[LEN] becomes the new acc MSB.
            acc_s = sum_s[LEN:1];
            mq_s  = {sum_s[0], mq_r[LEN-1:1]};
            cnt_s = cnt_r - CW'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            m_r   <= '0;
            acc_r <= '0;
            mq_r  <= '0;
        end else begin
            cnt_r <= cnt_s;
            m_r   <= m_s;
            acc_r <= acc_s;
            mq_r  <= mq_s;
        end
    end

    assign bus.done = (cnt_r == '0);
    assign bus.p_hi = acc_r;
    assign bus.p_lo = mq_r;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq -- self-checking bench for mul_seq (LEN=16). Products are
// predicted with plain integer multiplication; define MUL_SIGNED_EN for both
// bench and design to check the signed build.
module tb_mul_seq;
    localparam int LEN = 16;
    localparam int BUDGET = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mul_seq_if #(.LEN(LEN)) bus ();

    mul_seq #(.LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [2*LEN-1:0] ref_prod(input logic [LEN-1:0] x, input logic [LEN-1:0] y);
        logic [2*LEN-1:0] p;
`ifdef MUL_SIGNED_EN
        logic signed [LEN-1:0]   sx;
        logic signed [LEN-1:0]   sy;
        logic signed [2*LEN-1:0] sp;
        sx = x;
        sy = y;
        sp = sx * sy;
        p  = sp;
`else
        p = {{LEN{1'b0}}, x} * {{LEN{1'b0}}, y};
`endif
        return p;
    endfunction

    // Called at a negedge; the START edge is the following posedge.
    task automatic pulse_start(input logic [LEN-1:0] x, input logic [LEN-1:0] y);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts sampled cycles with done low; optionally scrambles a/b meanwhile.
    task automatic wait_done(input bit scramble, output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < BUDGET) begin
            cycles++;
            if (scramble) begin
                bus.a = LEN'($urandom);
                bus.b = LEN'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [LEN-1:0] x, input logic [LEN-1:0] y,
                          input bit scramble, output int cycles, output logic [2*LEN-1:0] prod);
        pulse_start(x, y);
        wait_done(scramble, cycles);
        prod = {bus.p_hi, bus.p_lo};
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a = LEN'($urandom);
        bus.b = LEN'($urandom);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            total++;
            if (bus.done !== 1'b1 || {bus.p_hi, bus.p_lo} !== 32'h0000_0000) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got done=%b p=%h want done=1 p=00000000",
                         i, bus.done, {bus.p_hi, bus.p_lo});
            end
            bus.a = LEN'($urandom);
            bus.b = LEN'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        int cycles;
        logic [2*LEN-1:0] prod;
        logic [2*LEN-1:0] exp;
        exp = ref_prod(16'd3, 16'd5);
        run_op(16'd3, 16'd5, 1'b0, cycles, prod);
        total++;
        if (cycles !== 16) begin
            bad++;
            $display("FAIL basic_latency got %0d want 16", cycles);
        end
        total++;
        if (prod !== exp) begin
            bad++;
            $display("FAIL basic_product got %h want %h", prod, exp);
        end
        // Result must hold while idle even though a/b wander.
        for (int i = 0; i < 10; i++) begin
            bus.a = LEN'($urandom);
            bus.b = LEN'($urandom);
            @(negedge clk);
            total++;
            if (bus.done !== 1'b1 || {bus.p_hi, bus.p_lo} !== exp) begin
                bad++;
                $display("FAIL basic_hold cyc=%0d got done=%b p=%h want done=1 p=%h",
                         i, bus.done, {bus.p_hi, bus.p_lo}, exp);
            end
        end
    endtask

    task automatic test_corners();
        logic [LEN-1:0] xs [8];
        logic [LEN-1:0] ys [8];
        int cycles;
        logic [2*LEN-1:0] prod;
        logic [2*LEN-1:0] exp;
        xs = '{16'hFFFF, 16'h8000, 16'h8000, 16'h0000, 16'h1357, 16'h0001, 16'h7FFF, 16'h8000};
        ys = '{16'hFFFF, 16'h8000, 16'h0001, 16'hBEEF, 16'h0000, 16'h0001, 16'h7FFF, 16'hFFFF};
        for (int i = 0; i < 8; i++) begin
            exp = ref_prod(xs[i], ys[i]);
            run_op(xs[i], ys[i], 1'b0, cycles, prod);
            total++;
            if (cycles !== 16 || prod !== exp) begin
                bad++;
                $display("FAIL corner a=%h b=%h got cyc=%0d p=%h want cyc=16 p=%h",
                         xs[i], ys[i], cycles, prod, exp);
            end
        end
    endtask

    task automatic test_random();
        int cycles;
        logic [LEN-1:0] x;
        logic [LEN-1:0] y;
        logic [2*LEN-1:0] prod;
        logic [2*LEN-1:0] exp;
        for (int i = 0; i < 25; i++) begin
            x = LEN'($urandom);
            y = LEN'($urandom);
            exp = ref_prod(x, y);
            // Odd iterations scramble a/b while busy; the latched operands must win.
            run_op(x, y, (i % 2) == 1, cycles, prod);
            total++;
            if (cycles !== 16 || prod !== exp) begin
                bad++;
                $display("FAIL random a=%h b=%h got cyc=%0d p=%h want cyc=16 p=%h",
                         x, y, cycles, prod, exp);
            end
        end
    endtask

    task automatic test_abort();
        int cycles;
        logic [2*LEN-1:0] exp;
        pulse_start(16'd7, 16'd9);
        repeat (4) @(negedge clk);
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy got done=%b want 0", bus.done);
        end
        exp = ref_prod(16'd12, 16'd12);
        pulse_start(16'd12, 16'd12);
        wait_done(1'b0, cycles);
        total++;
        if (cycles !== 16 || {bus.p_hi, bus.p_lo} !== exp) begin
            bad++;
            $display("FAIL abort_restart got cyc=%0d p=%h want cyc=16 p=%h",
                     cycles, {bus.p_hi, bus.p_lo}, exp);
        end
    endtask

    task automatic test_start_held();
        int cycles;
        logic [LEN-1:0] x;
        logic [LEN-1:0] y;
        logic [2*LEN-1:0] exp;
        x = '0;
        y = '0;
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = LEN'($urandom);
            y = LEN'($urandom);
            bus.a = x;
            bus.b = y;
            @(negedge clk);
            total++;
            if (bus.done !== 1'b0) begin
                bad++;
                $display("FAIL held_reload cyc=%0d got done=%b want 0", i, bus.done);
            end
        end
        bus.start = 1'b0;
        exp = ref_prod(x, y);
        wait_done(1'b0, cycles);
        total++;
        if (cycles !== 16 || {bus.p_hi, bus.p_lo} !== exp) begin
            bad++;
            $display("FAIL held_result got cyc=%0d p=%h want cyc=16 p=%h",
                     cycles, {bus.p_hi, bus.p_lo}, exp);
        end
    endtask

    task automatic test_rst_mid();
        int cycles;
        logic [2*LEN-1:0] prod;
        logic [2*LEN-1:0] exp;
        pulse_start(16'h1234, 16'h5678);
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        // Still 2 time units before the next rising edge.
        total++;
        if (bus.done !== 1'b1 || {bus.p_hi, bus.p_lo} !== 32'h0000_0000) begin
            bad++;
            $display("FAIL rst_async got done=%b p=%h want done=1 p=00000000",
                     bus.done, {bus.p_hi, bus.p_lo});
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 16'hABCD;
        bus.b = 16'h0FF0;
        @(negedge clk);
        total++;
        if (bus.done !== 1'b1 || {bus.p_hi, bus.p_lo} !== 32'h0000_0000) begin
            bad++;
            $display("FAIL rst_over_start got done=%b p=%h want done=1 p=00000000",
                     bus.done, {bus.p_hi, bus.p_lo});
        end
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        exp = ref_prod(16'd2, 16'd2);
        run_op(16'd2, 16'd2, 1'b0, cycles, prod);
        total++;
        if (cycles !== 16 || prod !== exp) begin
            bad++;
            $display("FAIL rst_then_op got cyc=%0d p=%h want cyc=16 p=%h", cycles, prod, exp);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_abort();
        test_start_held();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
